// File: rtl/focus_sharp_multi_if.sv
// Bus bundle for the focus/sharpness engine: table port, coefficient stream and results.
// dv qualifies di for exactly one cycle with no backpressure; blk_start, luma, blk_x/y and
// frame_first/last are only meaningful together with dv; all *_valid outputs are one-cycle strobes.
interface focus_sharp_multi_if #(
    parameter int NWIN   = 4,
    parameter int COEF_W = 13
);
    logic                     en;
    logic                     twe;
    logic [9:0]               ta;
    logic [15:0]              tdi;
    logic                     dv;
    logic                     blk_start;
    logic signed [COEF_W-1:0] di;
    logic                     luma;
    logic [8:0]               blk_x;
    logic [8:0]               blk_y;
    logic                     frame_first;
    logic                     frame_last;
    logic [11:0]              blk_sharp;
    logic                     blk_sharp_valid;
    logic [32*NWIN-1:0]       hifreq;
    logic                     hifreq_valid;
    logic                     busy;
    logic [1:0]               fsm_state;

    modport master (
        output en, twe, ta, tdi, dv, blk_start, di, luma, blk_x, blk_y, frame_first, frame_last,
        input  blk_sharp, blk_sharp_valid, hifreq, hifreq_valid, busy, fsm_state
    );

    modport slave (
        input  en, twe, ta, tdi, dv, blk_start, di, luma, blk_x, blk_y, frame_first, frame_last,
        output blk_sharp, blk_sharp_valid, hifreq, hifreq_valid, busy, fsm_state
    );
endinterface

// File: rtl/focus_sharp_multi.sv
// Per-block high-frequency energy from filtered DCT coefficients, accumulated per frame
// into up to four rectangular focus windows.
module focus_sharp_multi #(
    parameter int NWIN   = 4,
    parameter int COEF_W = 13,
    parameter int FRM_W  = 40
) (
    input logic                clk,
    input logic                rst,
    focus_sharp_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, COMMIT} state_t;

    localparam int PW = COEF_W + 17;
    localparam logic signed [PW-1:0] P_MAX = PW'(131071);
    localparam logic signed [PW-1:0] P_MIN = PW'(-131072);

    state_t state_q, state_d;
    logic   start, step, commit;

    logic [15:0] tab [0:959];
    logic        tab_we;
    logic [3:0]  sel_sh, sel_act, sel_eff, sel_rd;
    logic [8:0]  win_sh  [NWIN][4];
    logic [8:0]  win_act [NWIN][4];
    logic [NWIN-1:0] win_hit;

    logic [5:0]           idx_q, cidx;
    logic [15:0]          tab_val;
    logic signed [PW-1:0] prod_d, prod_q, prod_sh;
    logic signed [17:0]   p_sat;
    logic signed [35:0]   sq_full;
    logic [23:0]          term_d, term_q;
    logic                 v1_q, v2_q;
    logic [23:0]          acc_blk;
    logic [24:0]          acc_sum;

    logic       b_luma, b_ff, b_fl;
    logic [8:0] b_x, b_y;

    logic [FRM_W-1:0]   acc_frm [NWIN];
    logic [11:0]        sharp_q;
    logic               sharp_v_q, hf_pend_q, hf_v_q;
    logic [32*NWIN-1:0] hifreq_q;

    function automatic logic [FRM_W-1:0] frm_add(input logic [FRM_W-1:0] a, input logic [23:0] b);
        logic [FRM_W:0] s;
        s = {1'b0, a} + {{(FRM_W-23){1'b0}}, b};
        return s[FRM_W] ? {FRM_W{1'b1}} : s[FRM_W-1:0];
    endfunction

    // A restart (dv & blk_start) wins over every other transition, including the drain.
    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        commit  = 1'b0;
        start   = bus.en && bus.dv && bus.blk_start;
        case (state_q)
            IDLE:   if (start) state_d = ACCUM;
            ACCUM: begin
                if (start) begin
                    state_d = ACCUM;
                end else if (bus.dv) begin
                    step = 1'b1;
                    if (idx_q == 6'd63) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (start) begin
                    state_d = ACCUM;
                end else if (!v1_q && !v2_q) begin
                    state_d = COMMIT;
                    commit  = 1'b1;
                end
            end
            COMMIT:  state_d = start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
        if (!bus.en) begin
            state_d = IDLE;
            step    = 1'b0;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // The first coefficient of a frame_first block already uses the newly promoted filter.
    always_comb begin
        sel_eff = (start && bus.frame_first) ? sel_sh : sel_act;
        sel_rd  = (sel_eff == 4'hF) ? 4'h0 : sel_eff;
        cidx    = start ? 6'd0 : idx_q;
        tab_val = tab[{sel_rd, cidx}];
        prod_d  = $signed(bus.di) * $signed({1'b0, tab_val});
        prod_sh = prod_q >>> 15;
        if (prod_sh > P_MAX)      p_sat = P_MAX[17:0];
        else if (prod_sh < P_MIN) p_sat = P_MIN[17:0];
        else                      p_sat = prod_sh[17:0];
        sq_full = p_sat * p_sat;
        term_d  = 24'(sq_full >> 8);
        acc_sum = {1'b0, acc_blk} + {1'b0, term_q};
        for (int w = 0; w < NWIN; w++) begin
            win_hit[w] = b_luma
                && (b_x >= win_act[w][0]) && (b_x <= win_act[w][1])
                && (b_y >= win_act[w][2]) && (b_y <= win_act[w][3]);
        end
    end

    assign tab_we = bus.twe && (bus.ta[9:6] != 4'hF);

    always_ff @(posedge clk) begin
        if (tab_we) tab[bus.ta] <= bus.tdi;
    end

    // Block pipeline: multiply, saturate+square, accumulate. A restart drops whatever is in flight.
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            idx_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            prod_q    <= '0;
            term_q    <= '0;
            acc_blk   <= '0;
            sharp_v_q <= 1'b0;
            hf_pend_q <= 1'b0;
            hf_v_q    <= 1'b0;
        end else begin
            v1_q <= start || step;
            if (start || step) prod_q <= prod_d;
            v2_q <= v1_q && !start;
            if (v1_q) term_q <= term_d;
            if (start) begin
                idx_q   <= 6'd1;
                acc_blk <= '0;
            end else begin
                if (step) idx_q <= idx_q + 6'd1;
                if (v2_q) acc_blk <= acc_sum[24] ? 24'hFFFFFF : acc_sum[23:0];
            end
            sharp_v_q <= commit && b_luma;
            hf_pend_q <= commit && b_fl;
            hf_v_q    <= hf_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sharp_q  <= '0;
            hifreq_q <= '0;
            b_luma   <= 1'b0;
            b_ff     <= 1'b0;
            b_fl     <= 1'b0;
            b_x      <= '0;
            b_y      <= '0;
            sel_sh   <= '0;
            sel_act  <= '0;
            for (int w = 0; w < NWIN; w++) begin
                acc_frm[w]    <= '0;
                win_sh[w][0]  <= 9'd0;
                win_sh[w][1]  <= 9'h1FF;
                win_sh[w][2]  <= 9'd0;
                win_sh[w][3]  <= 9'h1FF;
                win_act[w][0] <= 9'd0;
                win_act[w][1] <= 9'h1FF;
                win_act[w][2] <= 9'd0;
                win_act[w][3] <= 9'h1FF;
            end
        end else begin
            if (start) begin
                b_luma <= bus.luma;
                b_ff   <= bus.frame_first;
                b_fl   <= bus.frame_last;
                b_x    <= bus.blk_x;
                b_y    <= bus.blk_y;
                if (bus.frame_first) begin
                    sel_act <= sel_sh;
                    win_act <= win_sh;
                end
            end
            if (bus.twe && bus.ta[9:4] == 6'b111100) begin
                for (int w = 0; w < NWIN; w++) begin
                    if (int'(bus.ta[3:2]) == w) win_sh[w][bus.ta[1:0]] <= bus.tdi[8:0];
                end
            end
            if (bus.twe && bus.ta == 10'h3F0) sel_sh <= bus.tdi[3:0];
            if (commit) begin
                if (b_luma) sharp_q <= (acc_blk[23:20] != 4'd0) ? 12'hFFF : acc_blk[19:8];
                for (int w = 0; w < NWIN; w++) begin
                    if (win_hit[w])  acc_frm[w] <= frm_add(b_ff ? '0 : acc_frm[w], acc_blk);
                    else if (b_ff)   acc_frm[w] <= '0;
                end
            end
            if (hf_pend_q) begin
                for (int w = 0; w < NWIN; w++) begin
                    hifreq_q[32*w +: 32] <= acc_frm[w][FRM_W-1 -: 32];
                end
            end
        end
    end

    assign bus.blk_sharp       = sharp_q;
    assign bus.blk_sharp_valid = sharp_v_q;
    assign bus.hifreq          = hifreq_q;
    assign bus.hifreq_valid    = hf_v_q;
    assign bus.busy            = (state_q == ACCUM) || (state_q == DRAIN);
    assign bus.fsm_state       = state_q;
endmodule

// File: tb/tb_focus_sharp_multi.sv
// Randomized scoreboard bench for focus_sharp_multi against a plain-arithmetic frame model.
`timescale 1ns/1ps
module tb_focus_sharp_multi;
    localparam int NWIN   = 4;
    localparam int COEF_W = 13;
    localparam int FRM_W  = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    focus_sharp_multi_if #(.NWIN(NWIN), .COEF_W(COEF_W)) bus();
    focus_sharp_multi #(.NWIN(NWIN), .COEF_W(COEF_W), .FRM_W(FRM_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0]        exp_q[$];
    int                 exp_cyc_q[$];
    logic [32*NWIN-1:0] exp_hf_q[$];

    int     tab_m [960];
    int     win_sh_m  [NWIN][4];
    int     win_act_m [NWIN][4];
    int     sel_sh_m, sel_act_m;
    longint frm_m [NWIN];
    int     coef [64];

    logic [11:0]        mon_e;
    int                 mon_c;
    logic [32*NWIN-1:0] mon_h;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.blk_sharp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected blk_sharp_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    check("blk_sharp", bus.blk_sharp, mon_e);
                    check("blk_sharp latency", cyc, mon_c);
                end
            end
            if (bus.hifreq_valid) begin
                if (exp_hf_q.size() == 0) begin
                    check("unexpected hifreq_valid", 1, 0);
                end else begin
                    mon_h = exp_hf_q.pop_front();
                    check("hifreq", bus.hifreq, mon_h);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int w = 0; w < NWIN; w++) begin
            win_sh_m[w]  = '{0, 511, 0, 511};
            win_act_m[w] = '{0, 511, 0, 511};
            frm_m[w]     = 0;
        end
        sel_sh_m  = 0;
        sel_act_m = 0;
    endtask

    task automatic reg_write(input int addr, input int data);
        bus.twe = 1'b1;
        bus.ta  = addr[9:0];
        bus.tdi = data[15:0];
        tick();
        bus.twe = 1'b0;
        if (addr < 960) tab_m[addr] = data & 'hFFFF;
        else if (addr >= 'h3C0 && addr < 'h3C0 + 4 * NWIN) win_sh_m[(addr - 'h3C0) / 4][addr % 4] = data & 'h1FF;
        else if (addr == 'h3F0) sel_sh_m = data & 'hF;
    endtask

    function automatic longint block_acc(input int sel);
        longint acc, p;
        int bank;
        acc  = 0;
        bank = (sel == 15) ? 0 : sel;
        for (int i = 0; i < 64; i++) begin
            p = (longint'(coef[i]) * longint'(tab_m[bank * 64 + i])) >>> 15;
            if (p > 131071) p = 131071;
            if (p < -131072) p = -131072;
            acc += ((p * p) >> 8) & 'hFFFFFF;
        end
        return (acc > 'hFFFFFF) ? 'hFFFFFF : acc;
    endfunction

    task automatic send_block(input bit luma, input int x, input int y, input bit ff, input bit fl,
                              input int ncoef, input int max_gap);
        int last_c, g;
        longint acc;
        logic [32*NWIN-1:0] hv;
        if (ff) begin
            sel_act_m = sel_sh_m;
            win_act_m = win_sh_m;
        end
        bus.dv = 1'b1; bus.blk_start = 1'b1; bus.luma = luma;
        bus.blk_x = x[8:0]; bus.blk_y = y[8:0];
        bus.frame_first = ff; bus.frame_last = fl;
        bus.di = COEF_W'(coef[0]);
        last_c = cyc;
        tick();
        for (int i = 1; i < ncoef; i++) begin
            g = $urandom_range(0, max_gap);
            bus.luma = 1'($urandom); bus.blk_x = 9'($urandom); bus.blk_y = 9'($urandom);
            bus.frame_first = 1'($urandom); bus.frame_last = 1'($urandom);
            bus.dv = 1'b0;
            repeat (g) begin
                bus.blk_start = 1'($urandom);
                bus.di = COEF_W'($urandom);
                tick();
            end
            bus.dv = 1'b1; bus.blk_start = 1'b0;
            bus.di = COEF_W'(coef[i]);
            last_c = cyc;
            tick();
        end
        bus.dv = 1'b0; bus.blk_start = 1'b0;
        if (ncoef == 64) begin
            acc = block_acc(sel_act_m);
            if (luma) begin
                exp_q.push_back((acc >= 'h100000) ? 12'hFFF : 12'(acc >> 8));
                exp_cyc_q.push_back(last_c + 4);
            end
            for (int w = 0; w < NWIN; w++) begin
                if (ff) frm_m[w] = 0;
                if (luma && x >= win_act_m[w][0] && x <= win_act_m[w][1] &&
                    y >= win_act_m[w][2] && y <= win_act_m[w][3]) begin
                    frm_m[w] += acc;
                    if (frm_m[w] > (64'd1 << FRM_W) - 1) frm_m[w] = (64'd1 << FRM_W) - 1;
                end
            end
            if (fl) begin
                for (int w = 0; w < NWIN; w++) hv[32*w +: 32] = 32'(frm_m[w] >> 8);
                exp_hf_q.push_back(hv);
            end
        end
    endtask

    task automatic rand_coefs();
        int amp;
        amp = $urandom_range(1, 4095);
        for (int i = 0; i < 64; i++) coef[i] = int'($urandom_range(0, 2 * amp)) - amp;
    endtask

    task automatic idle();
        repeat ($urandom_range(3, 6)) tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1; bus.twe = 1'b0; bus.ta = '0; bus.tdi = '0;
        bus.dv = 1'b0; bus.blk_start = 1'b0; bus.di = '0; bus.luma = 1'b0;
        bus.blk_x = '0; bus.blk_y = '0; bus.frame_first = 1'b0; bus.frame_last = 1'b0;
        model_reset();
        repeat (3) tick();
        @(negedge clk);
        check("reset blk_sharp", bus.blk_sharp, 0);
        check("reset blk_sharp_valid", bus.blk_sharp_valid, 0);
        check("reset hifreq", bus.hifreq, 0);
        check("reset hifreq_valid", bus.hifreq_valid, 0);
        check("reset busy", bus.busy, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 64; i++) begin
            reg_write(i, 'h8000);
            reg_write(64 + i, 'hFFFF);
            reg_write(128 + i, int'($urandom_range(0, 65535)));
        end

        // Single AC coefficient through the unity filter, two small windows and one empty window.
        reg_write('h3C0, 0); reg_write('h3C1, 7); reg_write('h3C2, 0); reg_write('h3C3, 7);
        reg_write('h3C4, 8); reg_write('h3C5, 9); reg_write('h3C6, 8); reg_write('h3C7, 9);
        reg_write('h3C8, 5); reg_write('h3C9, 4); reg_write('h3CA, 0); reg_write('h3CB, 511);
        reg_write('h3F0, 0);
        for (int i = 0; i < 64; i++) coef[i] = 0;
        coef[1] = 2048;
        send_block(1'b1, 3, 2, 1'b1, 1'b1, 64, 0);
        repeat (8) tick();
        check("unit block blk_sharp", bus.blk_sharp, 64);
        check("unit block hifreq w0", bus.hifreq[31:0], 64);
        check("unit block hifreq w1", bus.hifreq[63:32], 0);
        check("unit block hifreq w2 empty", bus.hifreq[95:64], 0);

        // Maximum table and coefficients saturate the block result.
        reg_write('h3F0, 1);
        for (int i = 0; i < 64; i++) coef[i] = 4095;
        send_block(1'b1, 0, 0, 1'b1, 1'b1, 64, 1);
        repeat (8) tick();
        check("saturated blk_sharp", bus.blk_sharp, 'hFFF);

        // Aborted block after 30 coefficients, then a complete block.
        reg_write('h3F0, 2);
        rand_coefs();
        send_block(1'b1, 1, 1, 1'b1, 1'b0, 30, 2);
        rand_coefs();
        send_block(1'b1, 1, 1, 1'b1, 1'b1, 64, 2);
        idle();

        // Frames with chroma interleaved, random windows and dv gaps.
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < NWIN; w++) begin
                reg_write('h3C0 + 4 * w, int'($urandom_range(0, 8)));
                reg_write('h3C1 + 4 * w, int'($urandom_range(0, 15)));
                reg_write('h3C2 + 4 * w, int'($urandom_range(0, 8)));
                reg_write('h3C3 + 4 * w, int'($urandom_range(0, 15)));
            end
            reg_write('h3F0, int'($urandom_range(0, 2)));
            for (int b = 0; b < 5; b++) begin
                rand_coefs();
                send_block(b % 2 == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           b == 0, (f == 2) ? (b == 3) : (b == 4), (f == 2 && b == 4) ? 64 : 64, 3);
                idle();
            end
        end

        // Reset mid-block at idx 40.
        rand_coefs();
        send_block(1'b1, 2, 2, 1'b1, 1'b1, 40, 1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid-block reset blk_sharp", bus.blk_sharp, 0);
        check("mid-block reset hifreq", bus.hifreq, 0);
        check("mid-block reset busy", bus.busy, 0);
        check("mid-block reset strobes", {bus.blk_sharp_valid, bus.hifreq_valid}, 0);
        rst = 1'b0;
        model_reset();
        tick();
        rand_coefs();
        send_block(1'b1, 5, 5, 1'b1, 1'b1, 64, 2);

        repeat (12) tick();
        check("blk_sharp strobes outstanding", exp_q.size(), 0);
        check("hifreq strobes outstanding", exp_hf_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/focus_sharp_multi.md
FOCUS_SHARP_MULTI -- requirements
Module: focus_sharp_multi

Interface
REQ-001 Parameter NWIN, 4, number of independent focus windows (1..4).
REQ-002 Parameter COEF_W, 13, signed DCT coefficient width.
REQ-003 Parameter FRM_W, 40, per-window frame accumulator width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 clk  in  1  pixel clock; all logic on posedge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 en  in  1  enable; 0 acts as soft reset of counters and FSM only (table and window registers kept).
REQ-008 twe  in  1  table/register write enable.
REQ-009 ta  in  10  table address.
REQ-010 tdi  in  16  table data.
REQ-011 dv  in  1  coefficient valid.
REQ-012 blk_start  in  1  qualifies first coefficient of a block (with dv).
REQ-013 di  in  COEF_W  signed DCT coefficient, zig-zag index order.
REQ-014 luma  in  1  block is Y; sampled with blk_start.
REQ-015 blk_x, blk_y  in  9 each  block coordinates in 8x8 units; sampled with blk_start.
REQ-016 frame_first, frame_last  in  1 each  block is first/last of frame; sampled with blk_start.
REQ-017 blk_sharp  out  12  per-block sharpness, unsigned.
REQ-018 blk_sharp_valid  out  1  one-cycle strobe.
REQ-019 hifreq  out  32*NWIN  per-window frame result; window w occupies bits [32w+31:32w].
REQ-020 hifreq_valid  out  1  one-cycle strobe, frame results updated.
REQ-021 busy  out  1  block in progress (ACCUM or DRAIN).

Function
REQ-022 Address map: ta[9:6]=0..14 filter bank; ta[5:0] coefficient index; unsigned 16-bit entry, 0x8000 = 1.0.
REQ-023 Address map: 0x3C0+4w+{0,1,2,3} -> left, right, top, bottom of window w (tdi[8:0], inclusive); 0x3F0 -> filt_sel (tdi[3:0], 15 treated as 0).
REQ-024 Window and filt_sel writes go to shadow registers; shadows copy to active registers on blk_start with frame_first=1.
REQ-025 FSM states: IDLE, ACCUM, DRAIN, COMMIT.
REQ-026 IDLE->ACCUM on dv&blk_start; idx<=1, acc_blk<=term(0).
REQ-027 ACCUM: each dv increments idx; dv gaps hold state.
REQ-028 ACCUM->DRAIN on dv at idx=63.
REQ-029 DRAIN->COMMIT after the 3-cycle arithmetic pipeline empties.
REQ-030 COMMIT->IDLE after one cycle; COMMIT->ACCUM directly if dv&blk_start in that cycle.
REQ-031 dv&blk_start in ACCUM or DRAIN: partial block discarded (no strobes, no frame update); new block starts.
REQ-032 Arithmetic: p=(di*tab[filt_sel][idx])>>>15, saturated to signed 18 bits.
REQ-033 Arithmetic: term=(p*p)[31:8].
REQ-034 Arithmetic: acc_blk is 24-bit unsigned, saturating at 0xFFFFFF.
REQ-035 blk_sharp = 0xFFF if acc_blk[23:20]!=0, else acc_blk[19:8].
REQ-036 blk_sharp_valid is asserted in COMMIT, 4 cycles after the 64th dv, luma blocks only.
REQ-037 In COMMIT, for each w with luma & left<=blk_x<=right & top<=blk_y<=bottom: acc_frm[w] += acc_blk, saturating at 2^FRM_W-1.
REQ-038 A frame_first block clears all acc_frm before its own COMMIT addition.
REQ-039 COMMIT of a frame_last block (any luma): hifreq[w]<=acc_frm[w][39:8] (after this block's add); hifreq_valid pulses the next cycle.
REQ-040 Table write to the active filter during ACCUM: affected coefficient undefined; all other state unaffected.
REQ-041 Window with left>right or top>bottom never accumulates and reports 0.

Reset
REQ-042 rst: FSM=IDLE; idx, acc_blk, acc_frm, blk_sharp, hifreq, all strobes, busy=0.
REQ-043 rst: window registers reset to left=top=0, right=bottom=0x1FF; filt_sel=0.
REQ-044 Table RAM contents are not reset.
REQ-045 rst mid-block aborts the block with no strobe.

Verification
REQ-046 Table bank 0 all 0x8000; luma block with di[1]=2048, other coefficients 0 -> blk_sharp=64, strobe 4 cycles after last dv.
REQ-047 Same block, frame_first=frame_last=1, window 0 = (0,0)-(7,7), block at (3,2), window 1 = (8,8)-(9,9) -> hifreq[0]=64, hifreq[1]=0, hifreq_valid once.
REQ-048 Table all 0xFFFF, all di=4095 -> blk_sharp=0xFFF.
REQ-049 blk_start reasserted after 30 coefficients -> no strobe for the first block; second block result correct.
REQ-050 Random dv gaps over a 3-block frame with chroma blocks interleaved -> hifreq equals model sum of luma blocks only.
REQ-051 rst asserted at idx=40 -> all outputs 0 next cycle; next block processed normally.
